// File: rtl/tqv_crc32_engine.sv
// tqv_crc32_engine
// CRC-32 (IEEE 802.3, reflected, init/final-xor 0xFFFFFFFF) accelerator on the
// TinyQV peripheral bus. Bus writes feed an input byte FIFO; a datapath FSM
// drains it into the CRC register. Reads of the CRC stall while work is pending.
//
// Optional build macro: CRC32_BYTE_PARALLEL_EN
//   defined   : one byte per cycle through an 8-bit unrolled update
//   undefined : bit-serial update, 8 cycles per byte
//
// Ports
//   clk            single clock
//   rst            synchronous, active-high reset
//   address        register byte address (0x00 CTRL, 0x04 DATA, 0x08 CRC, 0x0C STATUS)
//   data_in        write data, little-endian byte lanes
//   data_write_n   11 idle, 00 byte, 01 half, 10 word
//   data_read_n    11 idle, otherwise read (always 32 bits)
//   data_out       read data
//   data_ready     read data valid / access accepted
//   user_interrupt DONE & IRQ_EN, registered
//
// state  | meaning
// IDLE   | waiting for the FIFO to hold a byte
// SHIFT  | folding the current byte into the CRC

module tqv_crc32_engine #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] POLY       = 32'hEDB88320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_DATA   = 6'h04;
    localparam logic [5:0] ADDR_CRC    = 6'h08;
    localparam logic [5:0] ADDR_STATUS = 6'h0C;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {1'b0, c[31:1]} ^ (POLY & {32{c[0] ^ b}});
    endfunction

`ifdef CRC32_BYTE_PARALLEL_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = crc_step(r, b[i]);
        return r;
    endfunction
`endif

    state_e             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [7:0]         byte_q, byte_d;
`ifndef CRC32_BYTE_PARALLEL_EN
    logic [2:0]         bit_cnt_q, bit_cnt_d;
`endif
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               irq_en_q, irq_en_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               irq_q;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               wr_en, rd_en;
    logic               ctrl_wr, data_wr, status_wr, init;
    logic [2:0]         push_n;
    logic               push, pop;
    logic               busy, busy_d, full, stall;
    logic [31:0]        rd_data;

    assign wr_en     = (data_write_n != 2'b11);
    assign rd_en     = (data_read_n != 2'b11);
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign data_wr   = wr_en && (address == ADDR_DATA);
    assign status_wr = wr_en && (address == ADDR_STATUS);
    assign init      = ctrl_wr && data_in[0];
    assign busy      = (state_q != ST_IDLE) || (level_q != '0);
    assign full      = (level_q == LVL_W'(FIFO_DEPTH));

    always_comb begin
        case (data_write_n)
            2'b00:   push_n = 3'd1;
            2'b01:   push_n = 3'd2;
            2'b10:   push_n = 3'd4;
            default: push_n = 3'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        byte_d    = byte_q;
`ifndef CRC32_BYTE_PARALLEL_EN
        bit_cnt_d = bit_cnt_q;
`endif
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        pop       = 1'b0;
        // Free space is judged before any same-cycle pop; a write is all-or-nothing.
        push      = data_wr && (LVL_W'(push_n) <= (LVL_W'(FIFO_DEPTH) - level_q));

        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    byte_d  = mem_q[rd_ptr_q];
                    state_d = ST_SHIFT;
`ifndef CRC32_BYTE_PARALLEL_EN
                    bit_cnt_d = 3'd0;
`endif
                end
            end
            ST_SHIFT: begin
`ifdef CRC32_BYTE_PARALLEL_EN
                crc_d = crc_byte(crc_q, byte_q);
                if (level_q != '0) begin
                    pop    = 1'b1;
                    byte_d = mem_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
`else
                crc_d     = crc_step(crc_q, byte_q[bit_cnt_q]);
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (level_q != '0) begin
                        pop    = 1'b1;
                        byte_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        level_d = level_q + (push ? LVL_W'(push_n) : '0) - LVL_W'(pop);

        if (ctrl_wr) irq_en_d = data_in[1];

        // INIT discards the FIFO and any byte in flight.
        if (init) begin
            crc_d    = 32'hFFFF_FFFF;
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        busy_d = (state_d != ST_IDLE) || (level_d != '0);

        if (status_wr) begin
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end
        if (data_wr && !push) ovf_d = 1'b1;
        // DONE rises together with the BUSY falling edge.
        if (busy && !busy_d) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            crc_q     <= 32'hFFFF_FFFF;
            byte_q    <= 8'h00;
`ifndef CRC32_BYTE_PARALLEL_EN
            bit_cnt_q <= 3'd0;
`endif
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            byte_q    <= byte_d;
`ifndef CRC32_BYTE_PARALLEL_EN
            bit_cnt_q <= bit_cnt_d;
`endif
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            irq_q     <= done_d && irq_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < push_n) mem_q[wr_ptr_q + PTR_W'(i)] <= data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (address)
            ADDR_CTRL:   rd_data = {30'h0, irq_en_q, 1'b0};
            ADDR_CRC:    rd_data = ~crc_q;
            ADDR_STATUS: rd_data = {16'h0, 8'(level_q), 4'h0, done_q, ovf_q, full, busy};
            default:     rd_data = 32'h0;
        endcase
    end

    // A CRC read holds off until the datapath and FIFO have drained.
    assign stall          = rd_en && (address == ADDR_CRC) && busy;
    assign data_ready     = rst || !stall;
    assign data_out       = (rd_en && !stall && !rst) ? rd_data : 32'h0;
    assign user_interrupt = irq_q;

endmodule
